regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised multi-port register file with a per-register busy/tag scoreboard, the successor to the single-write, two-read register file.
- Serves the multi-issue core:
  - the decode/issue stage reserves destination registers;
  - up to NUM_WRITE writeback ports retire results tagged with a producer ID;
  - NUM_READ read ports return operand data, busy state and producer tag, with same-cycle writeback bypass.
- A flush clears all pending reservations without touching architectural data.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero.
- NUM_READ, 4, number of read ports.
- NUM_WRITE, 2, number of writeback ports.
- TAG_W, 4, width of the producer tag (ROB/RS index).
- IDX_W, $clog2(NUM_REGS), register index width (derived).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low: rst==0 at posedge resets.
- rd_addr  in  [NUM_READ][IDX_W]  read register indices.
- rd_data  out  [NUM_READ][XLEN]  read data (combinational).
- rd_busy  out  [NUM_READ]  source still awaiting a producer.
- rd_tag  out  [NUM_READ][TAG_W]  producer tag when rd_busy=1, else 0.
- rsv_valid  in  1  reserve a destination this cycle.
- rsv_dest  in  IDX_W  register to reserve.
- rsv_tag  in  TAG_W  producer tag to record.
- wb_valid  in  [NUM_WRITE]  writeback valid per port.
- wb_dest  in  [NUM_WRITE][IDX_W]  writeback register.
- wb_tag  in  [NUM_WRITE][TAG_W]  producer tag of the result.
- wb_data  in  [NUM_WRITE][XLEN]  result data.
- flush  in  1  clear all busy bits (pipeline squash).

Behaviour:
- State: data[NUM_REGS], busy[NUM_REGS], tag[NUM_REGS].
- Reset (rst==0 at posedge): all data, busy and tag entries become 0, overriding every other input.
  - Outputs are combinational, so after reset every read returns data 0, busy 0, tag 0.
- Register 0:
  - Writes and reservations to index 0 are ignored.
  - Reads of index 0 always return data 0, busy 0, tag 0, including under bypass.
- Writeback, per port p with wb_valid[p] and wb_dest[p]!=0, at posedge:
  - data[dest] <= wb_data[p] unconditionally (data is written regardless of tag match).
  - If busy[dest] and tag[dest]==wb_tag[p], clear busy[dest]. A stale tag leaves busy and tag unchanged.
  - If several ports target the same dest, the highest-index port wins for data; busy clears if any matching port's tag equals tag[dest].
- Reserve (rsv_valid, rsv_dest!=0): at posedge, busy[dest] <= 1 and tag[dest] <= rsv_tag.
  - Reserve takes priority over a same-cycle writeback clear to the same register: busy ends set with the new tag, and data still takes the writeback value.
- Flush: at posedge, all busy and tag entries are cleared.
  - A same-cycle reserve is dropped.
  - Same-cycle writebacks still update data.
  - rst==0 dominates flush.
- Reads (combinational, zero latency), per read port r with source index s:
  - Data bypass: if any valid writeback targets s (s!=0), rd_data = wb_data of the highest-index such port; otherwise data[s].
  - Busy/tag bypass: if busy[s] and a valid writeback to s carries a tag equal to tag[s], report rd_busy=0, rd_tag=0. Otherwise report busy[s] and tag[s] (tag forced to 0 when not busy).
  - A same-cycle reserve is not visible on read ports. Issue logic handles intra-bundle dependencies.
- No stalls and no handshakes; every request is accepted in the cycle it is presented.

Decomposition:
- Shared package regfile_pkg holds:
  - the XLEN, NUM_REGS, TAG_W and IDX_W defaults;
  - typedefs reg_idx_t, reg_tag_t, xlen_t;
  - struct wb_req_t {valid, dest, tag, data};
  - struct rd_rsp_t {data, busy, tag}.
- One sub-module, regfile_bypass: the per-read-port combinational priority select across the writeback ports, instantiated NUM_READ times.
- Storage and scoreboard update stay in the top module.

Test Plan:
- Reset: drive rst=0 for 2 cycles with wb_valid all set. Required: all 32 registers read data 0, busy 0, tag 0.
- Reserve then matching writeback:
  - Cycle 0: rsv x5 with tag 3. Cycle 1: x5 reads busy=1, tag=3.
  - Cycle 2: wb port1 writes x5, tag 3, data 0xDEADBEEF. The same cycle's read shows 0xDEADBEEF, busy=0.
  - Cycle 3: stored value 0xDEADBEEF, busy=0.
- Stale tag: x7 is reserved with tag 2, then re-reserved with tag 9. A writeback to x7 with tag 2 and data 0x11 updates data to 0x11; x7 stays busy=1 with tag 9.
- Conflicts:
  - wb0 and wb1 both write x4 with 0xAAAA and 0xBBBB. Required: x4 = 0xBBBB.
  - Same-cycle rsv x4 with tag 6. Required: busy=1, tag=6.
- x0 and flush:
  - Writeback and reserve to x0. Required: x0 reads 0, not busy.
  - Reserve x1..x3, then assert flush together with rsv x8. Required: all busy=0, x8 not busy, data unchanged.
- Reset mid-operation: rst=0 in the same cycle as a reserve and a writeback to x10. Required: next cycle x10 has data 0, busy 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, types and request/response structs for the multi-port
// register file with its busy/tag scoreboard.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int TAG_W    = 4;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [TAG_W-1:0] reg_tag_t;
  typedef logic [XLEN-1:0]  xlen_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    reg_tag_t tag;
    xlen_t    data;
  } wb_req_t;

  typedef struct packed {
    xlen_t    data;
    logic     busy;
    reg_tag_t tag;
  } rd_rsp_t;

endpackage

// File: rtl/regfile_bypass.sv
// One read port: merges stored data/busy/tag with same-cycle writebacks.
// The highest-index writeback port supplies the bypassed data.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int NUM_WRITE = 2
) (
  input  logic [IDX_W-1:0]               addr,
  input  wb_req_t [NUM_WRITE-1:0]        wb,
  input  logic [XLEN-1:0]                st_data,
  input  logic                           st_busy,
  input  logic [TAG_W-1:0]               st_tag,
  output rd_rsp_t                        rsp
);

  xlen_t data_sel;
  logic  clr;

  always_comb begin
    data_sel = st_data;
    clr      = 1'b0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (wb[p].valid && (wb[p].dest == addr)) begin
        data_sel = wb[p].data;
        if (st_busy && (wb[p].tag == st_tag)) clr = 1'b1;
      end
    end

    rsp = '0;
    if (addr != '0) begin
      rsp.data = data_sel;
      rsp.busy = st_busy && !clr;
      rsp.tag  = rsp.busy ? st_tag : '0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register busy/tag scoreboard,
// same-cycle writeback bypass on every read port, and flush of reservations.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_READ  = 4,
  parameter int NUM_WRITE = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_READ-1:0][IDX_W-1:0]    rd_addr,
  output logic [NUM_READ-1:0][XLEN-1:0]     rd_data,
  output logic [NUM_READ-1:0]               rd_busy,
  output logic [NUM_READ-1:0][TAG_W-1:0]    rd_tag,
  input  logic                              rsv_valid,
  input  logic [IDX_W-1:0]                  rsv_dest,
  input  logic [TAG_W-1:0]                  rsv_tag,
  input  logic [NUM_WRITE-1:0]              wb_valid,
  input  logic [NUM_WRITE-1:0][IDX_W-1:0]   wb_dest,
  input  logic [NUM_WRITE-1:0][TAG_W-1:0]   wb_tag,
  input  logic [NUM_WRITE-1:0][XLEN-1:0]    wb_data,
  input  logic                              flush
);

  logic [NUM_REGS-1:0][XLEN-1:0]  data_q;
  logic [NUM_REGS-1:0]            busy_q;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag_q;

  wb_req_t [NUM_WRITE-1:0] wb;

  // Writebacks to x0 are dropped here so neither storage nor bypass sees them.
  always_comb begin
    for (int p = 0; p < NUM_WRITE; p++) begin
      wb[p].valid = wb_valid[p] && (wb_dest[p] != '0);
      wb[p].dest  = wb_dest[p];
      wb[p].tag   = wb_tag[p];
      wb[p].data  = wb_data[p];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      // Later ports overwrite earlier ones, so the highest index wins on data.
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (wb[p].valid) begin
          data_q[wb[p].dest] <= wb[p].data;
          if (busy_q[wb[p].dest] && (tag_q[wb[p].dest] == wb[p].tag))
            busy_q[wb[p].dest] <= 1'b0;
        end
      end
      if (flush) begin
        busy_q <= '0;
        tag_q  <= '0;
      end else if (rsv_valid && (rsv_dest != '0)) begin
        busy_q[rsv_dest] <= 1'b1;
        tag_q[rsv_dest]  <= rsv_tag;
      end
    end
  end

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    rd_rsp_t rsp;

    regfile_bypass #(.NUM_WRITE(NUM_WRITE)) u_bypass (
      .addr    (rd_addr[r]),
      .wb      (wb),
      .st_data (data_q[rd_addr[r]]),
      .st_busy (busy_q[rd_addr[r]]),
      .st_tag  (tag_q[rd_addr[r]]),
      .rsp     (rsp)
    );

    assign rd_data[r] = rsp.data;
    assign rd_busy[r] = rsp.busy;
    assign rd_tag[r]  = rsp.tag;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reserve/writeback, stale tags,
// port conflicts, x0, flush and reset, with hand-computed expectations.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int NR = 4;
  localparam int NW = 2;

  logic                       clk;
  logic                       rst;
  logic [NR-1:0][IDX_W-1:0]   rd_addr;
  logic [NR-1:0][XLEN-1:0]    rd_data;
  logic [NR-1:0]              rd_busy;
  logic [NR-1:0][TAG_W-1:0]   rd_tag;
  logic                       rsv_valid;
  logic [IDX_W-1:0]           rsv_dest;
  logic [TAG_W-1:0]           rsv_tag;
  logic [NW-1:0]              wb_valid;
  logic [NW-1:0][IDX_W-1:0]   wb_dest;
  logic [NW-1:0][TAG_W-1:0]   wb_tag;
  logic [NW-1:0][XLEN-1:0]    wb_data;
  logic                       flush;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.NUM_READ(NR), .NUM_WRITE(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .rd_tag    (rd_tag),
    .rsv_valid (rsv_valid),
    .rsv_dest  (rsv_dest),
    .rsv_tag   (rsv_tag),
    .wb_valid  (wb_valid),
    .wb_dest   (wb_dest),
    .wb_tag    (wb_tag),
    .wb_data   (wb_data),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1ns after the edge; reads are sampled 1ns later, well before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input int idx, input logic [31:0] d,
                        input logic b, input logic [3:0] t);
    rd_addr[0] = IDX_W'(idx);
    #1;
    check({name, ".data"}, rd_data[0], d);
    check({name, ".busy"}, 32'(rd_busy[0]), 32'(b));
    check({name, ".tag"},  32'(rd_tag[0]),  32'(t));
  endtask

  task automatic idle();
    rsv_valid = 1'b0;
    wb_valid  = '0;
    flush     = 1'b0;
  endtask

  task automatic set_wb(input int p, input int dest, input logic [3:0] t, input logic [31:0] d);
    wb_valid[p] = 1'b1;
    wb_dest[p]  = IDX_W'(dest);
    wb_tag[p]   = t;
    wb_data[p]  = d;
  endtask

  task automatic set_rsv(input int dest, input logic [3:0] t);
    rsv_valid = 1'b1;
    rsv_dest  = IDX_W'(dest);
    rsv_tag   = t;
  endtask

  initial begin
    rd_addr = '0;
    rsv_dest = '0; rsv_tag = '0;
    wb_dest = '0; wb_tag = '0; wb_data = '0;
    idle();

    // Reset with both writeback ports active: reset must win.
    rst = 1'b0;
    set_wb(0, 9, 4'd1, 32'h55);
    set_wb(1, 12, 4'd2, 32'h66);
    set_rsv(9, 4'd1);
    step();
    step();
    rst = 1'b1;
    idle();
    #1;
    for (int g = 0; g < NUM_REGS / NR; g++) begin
      for (int r = 0; r < NR; r++) rd_addr[r] = IDX_W'(g * NR + r);
      #1;
      for (int r = 0; r < NR; r++) begin
        check($sformatf("rst.x%0d.data", g * NR + r), rd_data[r], 32'h0);
        check($sformatf("rst.x%0d.busy", g * NR + r), 32'(rd_busy[r]), 32'h0);
        check($sformatf("rst.x%0d.tag",  g * NR + r), 32'(rd_tag[r]),  32'h0);
      end
    end
    rd_addr = '0;

    // Reserve x5 tag 3, then matching writeback on port 1 with bypass.
    step();
    set_rsv(5, 4'd3);
    step();
    idle();
    rd_chk("rsv.x5", 5, 32'h0, 1'b1, 4'd3);
    step();
    set_wb(1, 5, 4'd3, 32'hDEADBEEF);
    rd_chk("wb.byp.x5", 5, 32'hDEADBEEF, 1'b0, 4'd0);
    step();
    idle();
    rd_chk("wb.st.x5", 5, 32'hDEADBEEF, 1'b0, 4'd0);

    // Stale tag: x7 tag 2 then re-reserved tag 9; writeback tag 2 only moves data.
    step();
    set_rsv(7, 4'd2);
    step();
    set_rsv(7, 4'd9);
    step();
    idle();
    set_wb(0, 7, 4'd2, 32'h11);
    rd_chk("stale.byp.x7", 7, 32'h11, 1'b1, 4'd9);
    step();
    idle();
    rd_chk("stale.st.x7", 7, 32'h11, 1'b1, 4'd9);

    // Both ports write x4 and a reserve hits x4 in the same cycle.
    step();
    set_wb(0, 4, 4'd0, 32'hAAAA);
    set_wb(1, 4, 4'd0, 32'hBBBB);
    set_rsv(4, 4'd6);
    rd_chk("conf.byp.x4", 4, 32'hBBBB, 1'b0, 4'd0);
    step();
    idle();
    rd_chk("conf.st.x4", 4, 32'hBBBB, 1'b1, 4'd6);

    // Reserve wins over a same-cycle matching clear; data still written.
    step();
    set_wb(0, 4, 4'd6, 32'h1234);
    set_rsv(4, 4'd7);
    rd_chk("rprio.byp.x4", 4, 32'h1234, 1'b0, 4'd0);
    step();
    idle();
    rd_chk("rprio.st.x4", 4, 32'h1234, 1'b1, 4'd7);

    // x0 ignores writeback and reserve, including on the bypass path.
    step();
    set_wb(0, 0, 4'd5, 32'hFFFF);
    set_rsv(0, 4'd5);
    rd_chk("x0.byp", 0, 32'h0, 1'b0, 4'd0);
    step();
    idle();
    rd_chk("x0.st", 0, 32'h0, 1'b0, 4'd0);

    // Reserve x1..x3 (x2 also gets data), then flush with rsv x8 and wb to x6.
    step();
    set_rsv(1, 4'd1);
    step();
    set_rsv(2, 4'd2);
    set_wb(0, 2, 4'd0, 32'h22);
    step();
    idle();
    set_rsv(3, 4'd3);
    step();
    idle();
    rd_chk("pre.x3", 3, 32'h0, 1'b1, 4'd3);
    step();
    flush = 1'b1;
    set_rsv(8, 4'd4);
    set_wb(1, 6, 4'd0, 32'h66);
    step();
    idle();
    rd_chk("fl.x1", 1, 32'h0, 1'b0, 4'd0);
    rd_chk("fl.x2", 2, 32'h22, 1'b0, 4'd0);
    rd_chk("fl.x3", 3, 32'h0, 1'b0, 4'd0);
    rd_chk("fl.x8", 8, 32'h0, 1'b0, 4'd0);
    rd_chk("fl.x6", 6, 32'h66, 1'b0, 4'd0);
    rd_chk("fl.x7", 7, 32'h11, 1'b0, 4'd0);
    rd_chk("fl.x5", 5, 32'hDEADBEEF, 1'b0, 4'd0);

    // Reset dominates a same-cycle reserve and writeback to x10.
    step();
    rst = 1'b0;
    set_rsv(10, 4'd5);
    set_wb(0, 10, 4'd5, 32'h77);
    step();
    rst = 1'b1;
    idle();
    rd_chk("mrst.x10", 10, 32'h0, 1'b0, 4'd0);
    rd_chk("mrst.x5", 5, 32'h0, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
